// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline boundary.
// Holds the core-wide bus widths and common constants, the packed
// write-back field bundle, and the per-edge pipeline update decision.
package mem_wb_stage_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;

  localparam logic [RegBus-1:0] ZeroWord     = '0;
  localparam logic              WriteEnable  = 1'b1;
  localparam logic              WriteDisable = 1'b0;
  localparam logic              Stop         = 1'b1;
  localparam logic              NoStop       = 1'b0;

  typedef logic [RegBus-1:0]     reg_t;
  typedef logic [RegAddrBus-1:0] regaddr_t;

  // Everything that travels from MEM into WB in one bundle.
  typedef struct packed {
    regaddr_t wd;
    logic     wreg;
    reg_t     wdata;
    logic     whilo;
    reg_t     hi;
    reg_t     lo;
    logic     llbit_we;
    logic     llbit_value;
  } wb_fields_t;

  typedef enum logic [1:0] {
    PIPE_LOAD,
    PIPE_BUBBLE,
    PIPE_HOLD
  } pipe_act_t;

  // Flush beats any stall. A stalled MEM feeding a running WB must inject a
  // bubble, otherwise the same instruction would commit twice.
  function automatic pipe_act_t pipe_action(input logic flush,
                                            input logic mem_stall,
                                            input logic wb_stall);
    if (flush == WriteEnable)
      return PIPE_BUBBLE;
    else if (mem_stall == Stop && wb_stall == NoStop)
      return PIPE_BUBBLE;
    else if (mem_stall == Stop)
      return PIPE_HOLD;
    else
      return PIPE_LOAD;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB boundary bus.
// master: MEM stage side, drives mem_* and observes wb_*.
// slave : the MEM/WB register, consumes mem_* and drives wb_*
//         (wb_wreg/wb_wd/wb_wdata go straight to the register file write port).
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  regaddr_t mem_wd;
  logic     mem_wreg;
  reg_t     mem_wdata;
  logic     mem_whilo;
  reg_t     mem_hi;
  reg_t     mem_lo;
  logic     mem_llbit_we;
  logic     mem_llbit_value;

  regaddr_t wb_wd;
  logic     wb_wreg;
  reg_t     wb_wdata;
  logic     wb_whilo;
  reg_t     wb_hi;
  reg_t     wb_lo;
  logic     wb_llbit_we;
  logic     wb_llbit_value;

  modport master (
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
           mem_llbit_we, mem_llbit_value,
    input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
           wb_llbit_we, wb_llbit_value
  );

  modport slave (
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
           mem_llbit_we, mem_llbit_value,
    output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
           wb_llbit_we, wb_llbit_value
  );

endinterface

// File: rtl/mem_wb_stage_hilo_reg.sv
// Architectural HI/LO register pair.
// Ports: clk, rst (sync, active-high), we (commit enable),
//        hi_i/lo_i (commit values), hi_o/lo_o (architectural values).
module hilo_reg
  import mem_wb_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  reg_t hi_i,
  input  reg_t lo_i,
  output reg_t hi_o,
  output reg_t lo_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= ZeroWord;
      lo_o <= ZeroWord;
    end else if (we == WriteEnable) begin
      hi_o <= hi_i;
      lo_o <= lo_i;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register of the OpenMIPS core.
// Registers the memory-stage results (one cycle latency) and drives the
// register-file write port directly; also owns architectural HI/LO and the
// LL bit, committed from the registered WB fields (so they lag WB by a cycle).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   stall[5:0]       pipeline stall vector (bit 4 = MEM, bit 5 = WB)
//   flush            exception flush pulse
//   bus (slave)      mem_* inputs / wb_* registered outputs
//   hi_o, lo_o       architectural HI/LO
//   llbit_o          architectural LL bit
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic                 flush,
  mem_wb_stage_if.slave        bus,
  output reg_t                 hi_o,
  output reg_t                 lo_o,
  output logic                 llbit_o
);

  wb_fields_t r_wb;
  wb_fields_t w_mem;
  pipe_act_t  w_act;
  logic       r_llbit;
  logic       w_unused_stall;

  // Only the MEM and WB stall bits matter at this boundary.
  assign w_unused_stall = ^stall[3:0];

  always_comb begin
    w_mem             = '0;
    w_mem.wd          = bus.mem_wd;
    w_mem.wreg        = bus.mem_wreg;
    w_mem.wdata       = bus.mem_wdata;
    w_mem.whilo       = bus.mem_whilo;
    w_mem.hi          = bus.mem_hi;
    w_mem.lo          = bus.mem_lo;
    w_mem.llbit_we    = bus.mem_llbit_we;
    w_mem.llbit_value = bus.mem_llbit_value;
    w_act             = pipe_action(flush, stall[4], stall[5]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb <= '0;
    end else begin
      case (w_act)
        PIPE_LOAD:   r_wb <= w_mem;
        PIPE_BUBBLE: r_wb <= '0;
        default:     r_wb <= r_wb;
      endcase
    end
  end

  assign bus.wb_wd          = r_wb.wd;
  assign bus.wb_wreg        = r_wb.wreg;
  assign bus.wb_wdata       = r_wb.wdata;
  assign bus.wb_whilo       = r_wb.whilo;
  assign bus.wb_hi          = r_wb.hi;
  assign bus.wb_lo          = r_wb.lo;
  assign bus.wb_llbit_we    = r_wb.llbit_we;
  assign bus.wb_llbit_value = r_wb.llbit_value;

  // The WB instruction is already committed when a flush arrives, so HI/LO
  // ignore flush and commit from the current WB fields.
  hilo_reg u_hilo_reg (
    .clk  (clk),
    .rst  (rst),
    .we   (r_wb.whilo),
    .hi_i (r_wb.hi),
    .lo_i (r_wb.lo),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

  // Flush kills any reservation, even against a simultaneous LL write.
  always_ff @(posedge clk) begin
    if (rst)
      r_llbit <= 1'b0;
    else if (flush)
      r_llbit <= 1'b0;
    else if (r_wb.llbit_we)
      r_llbit <= r_wb.llbit_value;
  end

  assign llbit_o = r_llbit;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        llbit_o;

  int checks   = 0;
  int failures = 0;

  mem_wb_stage_if u_if ();

  mem_wb_stage u_dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .flush   (flush),
    .bus     (u_if.slave),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .llbit_o (llbit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setmem(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                        input logic llwe, input logic llval);
    u_if.mem_wd          = wd;
    u_if.mem_wreg        = wreg;
    u_if.mem_wdata       = wdata;
    u_if.mem_whilo       = whilo;
    u_if.mem_hi          = hi;
    u_if.mem_lo          = lo;
    u_if.mem_llbit_we    = llwe;
    u_if.mem_llbit_value = llval;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wb_wd"},          {27'd0, u_if.wb_wd}, 32'd0);
    chk({tag, ".wb_wreg"},        {31'd0, u_if.wb_wreg}, 32'd0);
    chk({tag, ".wb_wdata"},       u_if.wb_wdata, 32'd0);
    chk({tag, ".wb_whilo"},       {31'd0, u_if.wb_whilo}, 32'd0);
    chk({tag, ".wb_hi"},          u_if.wb_hi, 32'd0);
    chk({tag, ".wb_lo"},          u_if.wb_lo, 32'd0);
    chk({tag, ".wb_llbit_we"},    {31'd0, u_if.wb_llbit_we}, 32'd0);
    chk({tag, ".wb_llbit_value"}, {31'd0, u_if.wb_llbit_value}, 32'd0);
    chk({tag, ".hi_o"},           hi_o, 32'd0);
    chk({tag, ".lo_o"},           lo_o, 32'd0);
    chk({tag, ".llbit_o"},        {31'd0, llbit_o}, 32'd0);
  endtask

  initial begin
    // Reset with busy inputs.
    rst = 1'b1; stall = '0; flush = 1'b0;
    setmem(5'd7, 1'b1, 32'hAAAA5555, 1'b1, 32'h11, 32'h22, 1'b1, 1'b1);
    step(); step();
    chk_all_zero("reset");

    rst = 1'b0;
    setmem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("post_reset.hi_o", hi_o, 32'd0);
    chk("post_reset.lo_o", lo_o, 32'd0);

    // Pass-through to the regfile port.
    setmem(5'd3, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("pass.wb_wreg",  {31'd0, u_if.wb_wreg}, 32'd1);
    chk("pass.wb_wd",    {27'd0, u_if.wb_wd}, 32'd3);
    chk("pass.wb_wdata", u_if.wb_wdata, 32'hDEADBEEF);

    // MEM stalled, WB running: bubble.
    stall = 6'b010000;
    setmem(5'd4, 1'b1, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("bubble.wb_wreg",  {31'd0, u_if.wb_wreg}, 32'd0);
    chk("bubble.wb_wdata", u_if.wb_wdata, 32'd0);
    chk("bubble.wb_wd",    {27'd0, u_if.wb_wd}, 32'd0);

    // Load, then hold for two stalled cycles.
    stall = 6'b000000;
    setmem(5'd5, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("load.wb_wd", {27'd0, u_if.wb_wd}, 32'd5);
    stall = 6'b110000;
    setmem(5'd6, 1'b1, 32'h11111111, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("hold1.wb_wd",    {27'd0, u_if.wb_wd}, 32'd5);
    chk("hold1.wb_wdata", u_if.wb_wdata, 32'hCAFEF00D);
    step();
    chk("hold2.wb_wd",    {27'd0, u_if.wb_wd}, 32'd5);
    chk("hold2.wb_wdata", u_if.wb_wdata, 32'hCAFEF00D);
    chk("hold2.wb_wreg",  {31'd0, u_if.wb_wreg}, 32'd1);

    stall = 6'b000000;
    step();
    chk("resume.wb_wd",    {27'd0, u_if.wb_wd}, 32'd6);
    chk("resume.wb_wdata", u_if.wb_wdata, 32'h11111111);

    // stall[5] alone is ignored when MEM runs.
    stall = 6'b100000;
    setmem(5'd9, 1'b1, 32'h00000099, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("wbstall_only.wb_wd",    {27'd0, u_if.wb_wd}, 32'd9);
    chk("wbstall_only.wb_wdata", u_if.wb_wdata, 32'h00000099);

    // HI/LO commit lags WB by a cycle.
    stall = 6'b000000;
    setmem(5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
    step();
    chk("hilo.wb_whilo", {31'd0, u_if.wb_whilo}, 32'd1);
    chk("hilo.wb_hi",    u_if.wb_hi, 32'h1);
    chk("hilo.wb_lo",    u_if.wb_lo, 32'h2);
    chk("hilo.hi_early", hi_o, 32'd0);
    setmem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("hilo.hi_o", hi_o, 32'h1);
    chk("hilo.lo_o", lo_o, 32'h2);

    // Flush on the commit edge still commits HI/LO.
    setmem(5'd0, 1'b0, 32'h0, 1'b1, 32'h3, 32'h4, 1'b0, 1'b0);
    step();
    flush = 1'b1;
    setmem(5'd0, 1'b0, 32'h0, 1'b1, 32'h5, 32'h6, 1'b0, 1'b0);
    step();
    chk("hilo_flush.hi_o",     hi_o, 32'h3);
    chk("hilo_flush.lo_o",     lo_o, 32'h4);
    chk("hilo_flush.wb_whilo", {31'd0, u_if.wb_whilo}, 32'd0);
    chk("hilo_flush.wb_hi",    u_if.wb_hi, 32'd0);
    flush = 1'b0;
    setmem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("hilo_after.hi_o", hi_o, 32'h3);
    chk("hilo_after.lo_o", lo_o, 32'h4);

    // LL bit set, then cleared by flush.
    setmem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    chk("ll.wb_llbit_we", {31'd0, u_if.wb_llbit_we}, 32'd1);
    chk("ll.early",       {31'd0, llbit_o}, 32'd0);
    setmem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("ll.set", {31'd0, llbit_o}, 32'd1);
    flush = 1'b1;
    step();
    chk("ll.flush", {31'd0, llbit_o}, 32'd0);

    // Flush beats a simultaneous LL write.
    flush = 1'b0;
    setmem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    chk("ll_race.pre", {31'd0, llbit_o}, 32'd0);
    flush = 1'b1;
    setmem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("ll_race.llbit_o",     {31'd0, llbit_o}, 32'd0);
    chk("ll_race.wb_llbit_we", {31'd0, u_if.wb_llbit_we}, 32'd0);
    flush = 1'b0;
    step();
    chk("ll_race.after", {31'd0, llbit_o}, 32'd0);

    // Flush beats a full stall.
    stall = 6'b000000;
    setmem(5'd10, 1'b1, 32'h0000ABCD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("fstall.loaded", u_if.wb_wdata, 32'h0000ABCD);
    stall = 6'b110000;
    flush = 1'b1;
    step();
    chk("fstall.wb_wreg",  {31'd0, u_if.wb_wreg}, 32'd0);
    chk("fstall.wb_wd",    {27'd0, u_if.wb_wd}, 32'd0);
    chk("fstall.wb_wdata", u_if.wb_wdata, 32'd0);
    flush = 1'b0;
    step();
    chk("fstall.held_bubble", u_if.wb_wdata, 32'd0);

    // Reset in the middle of a stall with live architectural state.
    stall = 6'b000000;
    setmem(5'd12, 1'b1, 32'h0000F0F0, 1'b1, 32'h9, 32'h8, 1'b1, 1'b1);
    step();
    setmem(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("prerst.hi_o",    hi_o, 32'h9);
    chk("prerst.llbit_o", {31'd0, llbit_o}, 32'd1);
    setmem(5'd12, 1'b1, 32'h0000F0F0, 1'b1, 32'h9, 32'h8, 1'b1, 1'b1);
    step();
    stall = 6'b110000;
    rst = 1'b1;
    step();
    chk_all_zero("rst_stall");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary of the OpenMIPS core.
- Registers the memory-stage results and drives the register-file write port (we/waddr/wdata) directly.
- Also holds the architectural HI/LO registers and the LL bit, committing them from the WB-stage fields.
- Honours the pipeline stall vector and the exception flush.

Parameters:
- None. Widths come from the shared defines: RegBus = 32 bits, RegAddrBus = 5 bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- stall  in  6  pipeline stall vector; bit 4 = MEM stalled, bit 5 = WB stalled
- flush  in  1  exception flush, one-cycle pulse
- mem_wd  in  5  destination GPR address
- mem_wreg  in  1  GPR write enable
- mem_wdata  in  32  GPR write data
- mem_whilo  in  1  HI/LO write enable
- mem_hi  in  32  HI write value
- mem_lo  in  32  LO write value
- mem_llbit_we  in  1  LL bit write enable
- mem_llbit_value  in  1  LL bit write value
- wb_wd  out  5  to regfile waddr
- wb_wreg  out  1  to regfile we
- wb_wdata  out  32  to regfile wdata
- wb_whilo  out  1  registered HI/LO write enable
- wb_hi  out  32  registered HI value
- wb_lo  out  32  registered LO value
- wb_llbit_we  out  1  registered LL bit write enable
- wb_llbit_value  out  1  registered LL bit value
- hi_o  out  32  architectural HI
- lo_o  out  32  architectural LO
- llbit_o  out  1  architectural LL bit

Behaviour:
- All state updates on posedge clk. All outputs are registered.

Reset:
- rst=1 at an edge clears every output to 0: pipeline fields, hi_o, lo_o, llbit_o.

Pipeline register update, priority order per edge:
- 1. rst: clear all fields.
- 2. flush=1: clear all wb_* fields (bubble).
- 3. stall[4]=1 and stall[5]=0: insert bubble, i.e. clear all wb_* fields. MEM is stalled, WB proceeds, so the instruction must not commit twice.
- 4. stall[4]=1 and stall[5]=1: hold all wb_* fields.
- 5. stall[4]=0: load every wb_* field from the matching mem_* input. stall[5] is ignored in this case.

Latency and register-file interface:
- One cycle from mem_* to wb_*.
- wb_wreg/wb_wd/wb_wdata drive the register file unmodified. The regfile's same-cycle read bypass covers WB-to-ID forwarding.
- wb_wd=0 with wb_wreg=1 is passed through unchanged. The regfile drops that write.

HI/LO commit:
- At each edge with rst=0 and wb_whilo=1: hi_o<=wb_hi, lo_o<=wb_lo. Otherwise hi_o/lo_o hold.
- Commit uses the current wb_* values, so HI/LO lag WB by one cycle.
- flush does not affect hi_o/lo_o; the WB instruction is already committed.
- While held (case 4), rewriting the same values is permitted because it is idempotent.

LL bit:
- At each edge with rst=0:
  - flush=1: llbit_o<=0. This has priority over a simultaneous write.
  - else if wb_llbit_we=1: llbit_o<=wb_llbit_value.
  - else: hold.

Simultaneous events:
- flush together with any stall: flush wins.
- rst mid-stall: reset wins and the stall state is discarded.

Decomposition:
- Shared defines file supplies RegBus, RegAddrBus, ZeroWord, WriteEnable/WriteDisable, Stop/NoStop. No new constants.
- One natural sub-module, hilo_reg: clk, rst, we, hi_i, lo_i, hi_o, lo_o. The LL bit is a few lines and stays inline.

Test Plan:
- Reset: rst=1 for 2 cycles with non-zero mem_* inputs -> every output 0; after rst drops, hi_o=lo_o=0 until the first whilo commit.
- Pass-through: mem_wreg=1, mem_wd=5'd3, mem_wdata=32'hDEADBEEF, stall=0 -> next cycle wb_wreg=1, wb_wd=3, wb_wdata=32'hDEADBEEF. A regfile read of r3 returns DEADBEEF that cycle via bypass and the cycle after from storage.
- Bubble vs hold:
  - stall=6'b010000 with mem_wreg=1 -> wb_wreg=0, wb_wdata=0.
  - stall=6'b110000 -> previous wb_* values held for every stalled cycle.
  - stall=0 -> new mem_* values loaded.
- HI/LO: mem_whilo=1, mem_hi=32'h1, mem_lo=32'h2 -> wb_whilo=1 at cycle+1, hi_o=1 and lo_o=2 at cycle+2. flush at cycle+2 leaves hi_o/lo_o unchanged.
- LL bit:
  - mem_llbit_we=1, value=1 -> llbit_o=1 two cycles later.
  - flush pulse -> llbit_o=0 next edge, including when wb_llbit_we=1 with value 1 on the same edge.
- Flush priority: flush=1 with stall=6'b110000 and valid wb_* fields -> all wb_* fields cleared next edge, not held.
